// File: rtl/pix_capture_pkg.sv
// pix_capture_pkg
//   Shared types and constants for the pixel capture controller.
//   state_t   : controller FSM states, also exported on the debug port
//   PixWidth  : sensor pixel / FIFO word width
package pix_capture_pkg;

    localparam int PixWidth = 12;

    typedef enum logic [2:0] {
        ST_FLUSH    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ARM      = 3'd2,
        ST_WAIT_SOF = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_DRAIN    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/pix_capture_ctrl_if.sv
// pix_capture_ctrl_if
//   Bundles every non-clock signal of the capture controller.
//   Command : cmd_trigger (in), cmd_ready (out)
//   Sensor  : pix_frameValid, pix_lineValid, pix_d (in)
//   FIFO    : fifo_din, fifo_d, fifo_qout (out); fifo_q, fifo_qValid (in)
//   Writer  : wr_valid, wr_data (out); wr_ready (in)
//   Status  : stat_done, stat_overflow, stat_pixelCount, dbg_state (out)
//   Modports: master = controller side, slave = surrounding system.
//
//   Handshake: a word moves on the writer port in every cycle where
//   wr_valid and wr_ready are both high at the rising clock edge; while
//   wr_valid is high and wr_ready low, wr_data holds its value and
//   wr_valid stays high.
interface pix_capture_ctrl_if #(
    parameter int CountWidth = 17
);
    import pix_capture_pkg::*;

    logic                  cmd_trigger;
    logic                  cmd_ready;
    logic                  pix_frameValid;
    logic                  pix_lineValid;
    logic [PixWidth-1:0]   pix_d;
    logic                  fifo_din;
    logic [PixWidth-1:0]   fifo_d;
    logic                  fifo_qout;
    logic [PixWidth-1:0]   fifo_q;
    logic                  fifo_qValid;
    logic                  wr_valid;
    logic [PixWidth-1:0]   wr_data;
    logic                  wr_ready;
    logic                  stat_done;
    logic                  stat_overflow;
    logic [CountWidth-1:0] stat_pixelCount;
    state_t                dbg_state;

    modport master (
        input  cmd_trigger, pix_frameValid, pix_lineValid, pix_d,
               fifo_q, fifo_qValid, wr_ready,
        output cmd_ready, fifo_din, fifo_d, fifo_qout, wr_valid, wr_data,
               stat_done, stat_overflow, stat_pixelCount, dbg_state
    );

    modport slave (
        output cmd_trigger, pix_frameValid, pix_lineValid, pix_d,
               fifo_q, fifo_qValid, wr_ready,
        input  cmd_ready, fifo_din, fifo_d, fifo_qout, wr_valid, wr_data,
               stat_done, stat_overflow, stat_pixelCount, dbg_state
    );

endinterface

// File: rtl/pix_capture_ctrl_fifo_occupancy.sv
// fifo_occupancy
//   Shadow word counter for a FIFO that has no full flag of its own.
//   clk, rst_   : clock, asynchronous active-low reset
//   i_push      : a word enters the FIFO this cycle
//   i_pop       : a word leaves the FIFO this cycle
//   o_occ       : words currently held, 0..Slots
//   o_full      : o_occ == Slots
//   o_empty     : o_occ == 0
module fifo_occupancy #(
    parameter int Slots    = 3,
    parameter int OccWidth = $clog2(Slots + 1)
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                i_push,
    input  logic                i_pop,
    output logic [OccWidth-1:0] o_occ,
    output logic                o_full,
    output logic                o_empty
);

    localparam logic [OccWidth-1:0] SlotsW = OccWidth'(Slots);

    logic [OccWidth-1:0] r_occ;

    // Push and pop together leave the count unchanged; the range guards
    // keep the counter inside 0..Slots even if a caller misbehaves.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_occ <= '0;
        end else if (i_push && !i_pop && (r_occ != SlotsW)) begin
            r_occ <= r_occ + OccWidth'(1);
        end else if (i_pop && !i_push && (r_occ != '0)) begin
            r_occ <= r_occ - OccWidth'(1);
        end
    end

    assign o_occ   = r_occ;
    assign o_full  = (r_occ == SlotsW);
    assign o_empty = (r_occ == '0);

endmodule

// File: rtl/pix_capture_ctrl.sv
// pix_capture_ctrl
//   Runs one sensor frame capture through an external pixel FIFO: arms on
//   a command, waits for a clean frame start, gates sensor pixels into the
//   FIFO and drains the FIFO to a downstream writer. Overflowing pixels are
//   dropped and flagged.
//   clk  : pixel clock, all logic on the rising edge
//   rst_ : asynchronous active-low reset
//   bus  : pix_capture_ctrl_if.master (command, sensor, FIFO, writer, status)
module pix_capture_ctrl #(
    parameter int Slots      = 3,
    parameter int MaxPixels  = 65536,
    parameter int CountWidth = 17
) (
    input  logic                  clk,
    input  logic                  rst_,
    pix_capture_ctrl_if.master    bus
);
    import pix_capture_pkg::*;

    localparam int OccWidth = $clog2(Slots + 1);
    localparam logic [CountWidth-1:0] MaxCnt = CountWidth'(MaxPixels);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_done;
    logic                  r_overflow;
    logic [CountWidth-1:0] r_count;

    logic                  w_xfer;
    logic                  w_wr_valid;
    logic                  w_pop;
    logic                  w_flush_pop;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_last_push;
    logic [OccWidth-1:0]   w_occ;
    logic                  w_full;
    logic                  w_empty;

    // Words are only offered downstream while a capture is being moved.
    assign w_xfer     = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
    assign w_wr_valid = w_xfer && bus.fifo_qValid;
    assign w_pop      = w_wr_valid && bus.wr_ready;

    // The FIFO cannot be reset, so stale words are discarded after reset.
    // Gated by rst_ so nothing is popped while reset is held.
    assign w_flush_pop = (r_state == ST_FLUSH) && bus.fifo_qValid && rst_;

    assign w_accept = (r_state == ST_CAPTURE) && bus.pix_frameValid &&
                      bus.pix_lineValid && (r_count < MaxCnt);
    // A pop in the same cycle frees the slot the push needs.
    assign w_push      = w_accept && (!w_full || w_pop);
    assign w_drop      = w_accept && w_full && !w_pop;
    assign w_last_push = w_push && (r_count == (MaxCnt - CountWidth'(1)));

    fifo_occupancy #(
        .Slots    (Slots),
        .OccWidth (OccWidth)
    ) u_occ (
        .clk     (clk),
        .rst_    (rst_),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_occ   (w_occ),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= ST_FLUSH;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_push) begin
                r_count <= r_count + CountWidth'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                ST_FLUSH: begin
                    if (!bus.fifo_qValid) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (bus.cmd_trigger) begin
                        r_state     <= ST_ARM;
                        r_cmd_ready <= 1'b0;
                        r_done      <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_count     <= '0;
                    end
                end
                ST_ARM: begin
                    // Never start in the middle of a frame.
                    if (!bus.pix_frameValid) begin
                        r_state <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (bus.pix_frameValid) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!bus.pix_frameValid || w_last_push ||
                        (r_count == MaxCnt)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && !w_pop) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_FLUSH;
                end
            endcase
        end
    end

    assign bus.fifo_din        = w_push;
    assign bus.fifo_d          = bus.pix_d;
    assign bus.fifo_qout       = w_pop || w_flush_pop;
    assign bus.wr_valid        = w_wr_valid;
    assign bus.wr_data         = bus.fifo_q;
    assign bus.cmd_ready       = r_cmd_ready;
    assign bus.stat_done       = r_done;
    assign bus.stat_overflow   = r_overflow;
    assign bus.stat_pixelCount = r_count;
    assign bus.dbg_state       = r_state;

    // Outside Flush the shadow count must agree with the FIFO's own flag.
    a_occ_matches_fifo : assert property (
        @(posedge clk) disable iff (!rst_)
        (r_state != ST_FLUSH) |-> ((w_occ == '0) == !bus.fifo_qValid)
    );

endmodule

// File: tb/tb_pix_capture_ctrl.sv
module tb_pix_capture_ctrl;
  import pix_capture_pkg::*;

  localparam int SLOTS = 3;
  localparam int MAXPIX = 16;
  localparam int CW = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  pix_capture_ctrl_if #(.CountWidth(CW)) bus();

  pix_capture_ctrl #(.Slots(SLOTS), .MaxPixels(MAXPIX), .CountWidth(CW)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // ---------------- FIFO model (real FIFO, evicts oldest on full push) ----
  logic [11:0] fq[$];
  logic        m_valid = 1'b0;
  logic [11:0] m_q = 12'h000;
  logic        seed_en = 1'b0;

  always @(posedge clk) begin
    if (seed_en) begin
      fq.delete();
      fq.push_back(12'h5A5);
      fq.push_back(12'h5A6);
    end else begin
      if (bus.fifo_qout && fq.size() != 0) void'(fq.pop_front());
      if (bus.fifo_din) begin
        if (fq.size() >= SLOTS) void'(fq.pop_front());
        fq.push_back(bus.fifo_d);
      end
    end
    m_valid <= (fq.size() != 0);
    m_q     <= (fq.size() != 0) ? fq[0] : 12'h000;
  end
  assign bus.fifo_qValid = m_valid;
  assign bus.fifo_q      = m_q;

  // ---------------- observation log ----------------
  logic [11:0] wr_log[$];
  logic [11:0] exp_q[$];
  int push_cnt = 0;
  int flush_pops = 0;
  bit flush_wr_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_) begin
      if (bus.wr_valid && bus.wr_ready) wr_log.push_back(bus.wr_data);
      if (bus.fifo_din) push_cnt++;
      if (bus.fifo_qout && bus.dbg_state == ST_FLUSH) flush_pops++;
      if (bus.wr_valid && bus.dbg_state == ST_FLUSH) flush_wr_seen = 1'b1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic fv, input logic lv, input logic [11:0] d);
    bus.pix_frameValid = fv;
    bus.pix_lineValid  = lv;
    bus.pix_d          = d;
    tick();
  endtask

  task automatic trigger();
    bus.cmd_trigger = 1'b1;
    tick();
    bus.cmd_trigger = 1'b0;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    exp_q.delete();
    push_cnt = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !bus.stat_done; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ = 1'b0;
    seed_en = 1'b1;
    tick();
    seed_en = 1'b0;
    tick();
    n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); end
    n_vec++; if (bus.fifo_qout !== 1'b0) begin n_err++; $display("FAIL rst_fifo_qout: got %b want 0", bus.fifo_qout); end
    n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid: got %b want 0", bus.wr_valid); end
    n_vec++; if (bus.stat_pixelCount !== 17'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus.stat_pixelCount); end
    flush_pops = 0;
    flush_wr_seen = 1'b0;
    rst_ = 1'b1;
    tick();
    tick();
    n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL flush_cmd_ready_early: got %b want 0", bus.cmd_ready); end
    tick();
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL flush_cmd_ready_3rd: got %b want 1", bus.cmd_ready); end
    n_vec++; if (flush_pops !== 2) begin n_err++; $display("FAIL flush_pops: got %0d want 2", flush_pops); end
    n_vec++; if (flush_wr_seen !== 1'b0) begin n_err++; $display("FAIL flush_wr_valid: got %b want 0", flush_wr_seen); end
    n_vec++; if (bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL flush_to_idle: got %0d want %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_basic_frame();
    logic [11:0] got;
    clear_logs();
    bus.wr_ready = 1'b1;
    trigger();
    n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL basic_cmd_ready: got %b want 0", bus.cmd_ready); end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 1; i <= 4; i++) begin cyc(1, 1, 12'(i)); exp_q.push_back(12'(i)); end
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 5; i <= 8; i++) begin cyc(1, 1, 12'(i)); exp_q.push_back(12'(i)); end
    cyc(0, 0, 0);
    wait_done();
    n_vec++; if (bus.stat_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", bus.stat_done); end
    n_vec++; if (bus.stat_pixelCount !== 17'd8) begin n_err++; $display("FAIL basic_count: got %0d want 8", bus.stat_pixelCount); end
    n_vec++; if (bus.stat_overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b want 0", bus.stat_overflow); end
    n_vec++; if (wr_log.size() != exp_q.size()) begin n_err++; $display("FAIL basic_nwrites: got %0d want %0d", wr_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL basic_word%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] got;
    clear_logs();
    bus.wr_ready = 1'b0;
    trigger();
    n_vec++; if (bus.stat_done !== 1'b0) begin n_err++; $display("FAIL ovf_done_cleared: got %b want 0", bus.stat_done); end
    n_vec++; if (bus.stat_pixelCount !== 17'd0) begin n_err++; $display("FAIL ovf_count_cleared: got %0d want 0", bus.stat_pixelCount); end
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 12'h0A1);
    cyc(1, 1, 12'h0A2);
    cyc(1, 1, 12'h0A3);
    cyc(1, 1, 12'h0A4);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    n_vec++; if (bus.stat_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", bus.stat_overflow); end
    n_vec++; if (bus.stat_pixelCount !== 17'd3) begin n_err++; $display("FAIL ovf_count: got %0d want 3", bus.stat_pixelCount); end
    n_vec++; if (bus.wr_valid !== 1'b1) begin n_err++; $display("FAIL ovf_wr_valid_held: got %b want 1", bus.wr_valid); end
    n_vec++; if (bus.wr_data !== 12'h0A1) begin n_err++; $display("FAIL ovf_wr_data_held: got %h want 0a1", bus.wr_data); end
    exp_q.push_back(12'h0A1); exp_q.push_back(12'h0A2); exp_q.push_back(12'h0A3);
    bus.wr_ready = 1'b1;
    wait_done();
    n_vec++; if (bus.stat_done !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %b want 1", bus.stat_done); end
    n_vec++; if (wr_log.size() != 3) begin n_err++; $display("FAIL ovf_nwrites: got %0d want 3", wr_log.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL ovf_word%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_max_pixels();
    logic [11:0] got;
    clear_logs();
    bus.wr_ready = 1'b1;
    trigger();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 1, 12'(i));
      if (i <= 16) exp_q.push_back(12'(i));
      if (i == 16) begin
        n_vec++; if (bus.dbg_state !== ST_DRAIN) begin n_err++; $display("FAIL max_drain_entry: got %0d want %0d", bus.dbg_state, ST_DRAIN); end
      end
    end
    cyc(0, 0, 0);
    wait_done();
    n_vec++; if (bus.stat_done !== 1'b1) begin n_err++; $display("FAIL max_done: got %b want 1", bus.stat_done); end
    n_vec++; if (push_cnt !== 16) begin n_err++; $display("FAIL max_pushes: got %0d want 16", push_cnt); end
    n_vec++; if (bus.stat_pixelCount !== 17'd16) begin n_err++; $display("FAIL max_count: got %0d want 16", bus.stat_pixelCount); end
    n_vec++; if (wr_log.size() != 16) begin n_err++; $display("FAIL max_nwrites: got %0d want 16", wr_log.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL max_word%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_mid_frame_trigger();
    logic [11:0] got;
    clear_logs();
    bus.wr_ready = 1'b1;
    cyc(1, 1, 12'h300);
    bus.pix_frameValid = 1'b1;
    bus.pix_lineValid  = 1'b1;
    bus.pix_d          = 12'h301;
    trigger();
    for (int i = 2; i <= 4; i++) cyc(1, 1, 12'h300 + 12'(i));
    n_vec++; if (push_cnt !== 0) begin n_err++; $display("FAIL mid_no_push_first_frame: got %0d want 0", push_cnt); end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 1; i <= 4; i++) begin cyc(1, 1, 12'h400 + 12'(i)); exp_q.push_back(12'h400 + 12'(i)); end
    cyc(0, 0, 0);
    wait_done();
    n_vec++; if (bus.stat_done !== 1'b1) begin n_err++; $display("FAIL mid_done: got %b want 1", bus.stat_done); end
    n_vec++; if (wr_log.size() != 4) begin n_err++; $display("FAIL mid_nwrites: got %0d want 4", wr_log.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL mid_word%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back_full();
    logic [11:0] got;
    clear_logs();
    bus.wr_ready = 1'b0;
    trigger();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 12'h501);
    cyc(1, 1, 12'h502);
    cyc(1, 1, 12'h503);
    // FIFO full; pop and push in the same cycle.
    bus.wr_ready = 1'b1;
    bus.pix_d    = 12'h504;
    #2;
    n_vec++; if (bus.fifo_din !== 1'b1) begin n_err++; $display("FAIL b2b_push: got %b want 1", bus.fifo_din); end
    n_vec++; if (bus.fifo_qout !== 1'b1) begin n_err++; $display("FAIL b2b_pop: got %b want 1", bus.fifo_qout); end
    tick();
    n_vec++; if (bus.stat_overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b want 0", bus.stat_overflow); end
    n_vec++; if (bus.stat_pixelCount !== 17'd4) begin n_err++; $display("FAIL b2b_count: got %0d want 4", bus.stat_pixelCount); end
    // Occupancy stayed at 3, so a stalled push now must be dropped.
    bus.wr_ready = 1'b0;
    cyc(1, 1, 12'h505);
    n_vec++; if (bus.stat_overflow !== 1'b1) begin n_err++; $display("FAIL b2b_still_full: got %b want 1", bus.stat_overflow); end
    cyc(0, 0, 0);
    bus.wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(12'h500 + 12'(i));
    wait_done();
    n_vec++; if (bus.stat_done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %b want 1", bus.stat_done); end
    n_vec++; if (wr_log.size() != 4) begin n_err++; $display("FAIL b2b_nwrites: got %0d want 4", wr_log.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      n_vec++; if (got !== exp_q[i]) begin n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    clear_logs();
    bus.wr_ready = 1'b0;
    trigger();
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 12'h601);
    cyc(1, 1, 12'h602);
    bus.pix_d = 12'h603;
    #2;
    rst_ = 1'b0;
    #1;
    n_vec++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL arst_cmd_ready: got %b want 0", bus.cmd_ready); end
    n_vec++; if (bus.fifo_din !== 1'b0) begin n_err++; $display("FAIL arst_fifo_din: got %b want 0", bus.fifo_din); end
    n_vec++; if (bus.fifo_qout !== 1'b0) begin n_err++; $display("FAIL arst_fifo_qout: got %b want 0", bus.fifo_qout); end
    n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL arst_wr_valid: got %b want 0", bus.wr_valid); end
    n_vec++; if (bus.stat_pixelCount !== 17'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus.stat_pixelCount); end
    n_vec++; if (bus.stat_done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b want 0", bus.stat_done); end
    n_vec++; if (bus.dbg_state !== ST_FLUSH) begin n_err++; $display("FAIL arst_state: got %0d want %0d", bus.dbg_state, ST_FLUSH); end
    tick();
    bus.pix_frameValid = 1'b0;
    bus.pix_lineValid  = 1'b0;
    rst_ = 1'b1;
    for (int i = 0; i < 10 && !bus.cmd_ready; i++) tick();
    n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL arst_cmd_ready_after: got %b want 1", bus.cmd_ready); end
    n_vec++; if (bus.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL arst_idle: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    n_vec++; if (bus.stat_done !== 1'b0) begin n_err++; $display("FAIL arst_no_partial_done: got %b want 0", bus.stat_done); end
    n_vec++; if (wr_log.size() != 0) begin n_err++; $display("FAIL arst_no_writes: got %0d want 0", wr_log.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.cmd_trigger    = 1'b0;
    bus.pix_frameValid = 1'b0;
    bus.pix_lineValid  = 1'b0;
    bus.pix_d          = 12'h000;
    bus.wr_ready       = 1'b1;
    #1;
    test_reset();
    test_basic_frame();
    test_overflow();
    test_max_pixels();
    test_mid_frame_trigger();
    test_back_to_back_full();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
